// File: rtl/in_line_buffer.sv
// -----------------------------------------------------------------------------
// in_line_buffer
//
// Captures one image frame from an AXI4-Stream slave into on-chip RAM, then
// replays it (i_repeat+1 times) to the PE array as K-row vertical slices.
// Every border is zero padded: each output row carries PAD extra all-zero
// columns on both sides. Lanes whose row lies above or below the image are
// zero.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   s_axis_*         frame input, PPB = BEAT_W/DW pixels per beat, lowest
//                    pixel in bits [DW-1:0], row-major order
//   i_start          one-cycle pulse; arms a load when idle
//   i_repeat         number of passes minus one, sampled on i_start
//   o_col            K lanes; lane i = pixel(row r-PAD+i, column c-PAD) or 0
//   o_valid/i_ready  output handshake
//   o_row_last       marks the final slice of an output row
//   o_pass_last      marks the final slice of a pass
//   o_done           one-cycle pulse after the final slice of the final pass
//   o_err            sticky tlast position error, cleared by i_start
//
// Datapath: generator (pass/row/col counters) -> K parallel RAM reads
// (1-cycle latency) -> 2-entry skid FIFO -> output register.
// -----------------------------------------------------------------------------
module in_line_buffer #(
  parameter int DW     = 8,
  parameter int BEAT_W = 32,
  parameter int IMG_W  = 48,
  parameter int IMG_H  = 48,
  parameter int K      = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              i_start,
  input  logic [7:0]        i_repeat,
  output logic [K*DW-1:0]   o_col,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_row_last,
  output logic              o_pass_last,
  output logic              o_done,
  output logic              o_err
);

  function automatic int clog2g(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PPB  = BEAT_W / DW;
  localparam int PAD  = (K - 1) / 2;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NB   = NPIX / PPB;
  localparam int COLS = IMG_W + 2 * PAD;
  localparam int AW   = clog2g(NPIX);
  localparam int BC_W = clog2g(NB);
  localparam int R_W  = clog2g(IMG_H);
  localparam int C_W  = clog2g(COLS);

  localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(NB - 1);
  localparam logic [R_W-1:0]  R_LAST    = R_W'(IMG_H - 1);
  localparam logic [C_W-1:0]  C_LAST    = C_W'(COLS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} state_t;

  typedef struct packed {
    logic [K*DW-1:0] col;
    logic            row_last;
    logic            pass_last;
    logic            fin;        // final slice of the final pass
  } slice_t;

  state_t          state;
  logic [7:0]      rep;
  logic [BC_W-1:0] beat_cnt;

  // Slice generator
  logic            gen_busy;
  logic [7:0]      gen_p;
  logic [R_W-1:0]  gen_r;
  logic [C_W-1:0]  gen_c;
  logic            gen_row_last;
  logic            gen_pass_last;
  logic            gen_fin;

  // Read stage
  logic [K-1:0]    lane_ok;
  logic [AW-1:0]   rd_addr [K];
  logic            rd_valid;
  logic [K-1:0]    rd_mask;
  logic            rd_row_last;
  logic            rd_pass_last;
  logic            rd_fin;
  logic [DW-1:0]   ram_q [K];
  slice_t          rd_slice;

  // Skid FIFO and output stage
  slice_t          fifo_mem [2];
  logic            fifo_wp;
  logic            fifo_rp;
  logic [1:0]      fifo_cnt;
  logic [1:0]      occ_next;
  logic            o_fin;

  logic            in_hs;
  logic            out_hs;
  logic            pop;
  logic            push;
  logic            issue;

  logic [DW-1:0]   mem [NPIX];

  assign s_axis_tready = (state == ST_LOAD);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = o_valid && i_ready;

  assign gen_row_last  = (gen_c == C_LAST);
  assign gen_pass_last = gen_row_last && (gen_r == R_LAST);
  assign gen_fin       = gen_pass_last && (gen_p == rep);

  // A read may be issued only if its data will find room in the FIFO the
  // cycle it arrives; occ_next is the FIFO occupancy seen by that arrival
  // before any pop, which keeps one slice per cycle with i_ready high.
  assign pop      = (fifo_cnt != 2'd0) && (!o_valid || i_ready);
  assign push     = rd_valid;
  assign occ_next = fifo_cnt - {1'b0, pop} + {1'b0, rd_valid};
  assign issue    = gen_busy && (occ_next < 2'd2);

  // Per-lane address and in-image test for the slice being generated.
  always_comb begin
    int row_i;
    int col_i;
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    row_i   = 0;
    col_i   = int'(gen_c) - PAD;
    lane_ok = '0;
    for (int i = 0; i < K; i++) begin
      row_i      = int'(gen_r) + i - PAD;
      lane_ok[i] = (row_i >= 0) && (row_i < IMG_H) && (col_i >= 0) && (col_i < IMG_W);
      rd_addr[i] = lane_ok[i] ? AW'(row_i * IMG_W + col_i) : '0;
    end
  end

  // Padding lanes are forced to zero after the read.
  always_comb begin
    rd_slice           = '0;
    rd_slice.row_last  = rd_row_last;
    rd_slice.pass_last = rd_pass_last;
    rd_slice.fin       = rd_fin;
    for (int i = 0; i < K; i++) begin
      rd_slice.col[i*DW +: DW] = rd_mask[i] ? ram_q[i] : '0;
    end
  end

  // Control FSM, slice generator and status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state    <= ST_IDLE;
      rep      <= '0;
      beat_cnt <= '0;
      gen_busy <= 1'b0;
      gen_p    <= '0;
      gen_r    <= '0;
      gen_c    <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state    <= ST_LOAD;
            rep      <= i_repeat;
            beat_cnt <= '0;
            o_err    <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (in_hs) begin
            // tlast must appear exactly on the final beat; either mismatch
            // flags an error but the load is still counted out in beats.
            if (s_axis_tlast != (beat_cnt == BEAT_LAST)) begin
              o_err <= 1'b1;
            end
            if (beat_cnt == BEAT_LAST) begin
              state    <= ST_SEND;
              beat_cnt <= '0;
              gen_busy <= 1'b1;
              gen_p    <= '0;
              gen_r    <= '0;
              gen_c    <= '0;
            end else begin
              beat_cnt <= beat_cnt + BC_W'(1);
            end
          end
        end

        ST_SEND: begin
          if (issue) begin
            if (gen_row_last) begin
              gen_c <= '0;
              if (gen_r == R_LAST) begin
                gen_r <= '0;
                if (gen_p == rep) begin
                  gen_busy <= 1'b0;
                end else begin
                  gen_p <= gen_p + 8'd1;
                end
              end else begin
                gen_r <= gen_r + R_W'(1);
              end
            end else begin
              gen_c <= gen_c + C_W'(1);
            end
          end
          if (out_hs && o_fin) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame RAM, its read registers and the FIFO storage.
  // NOTE: storage arrays are deliberately not reset; their contents are only
  // consumed after being written, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int j = 0; j < PPB; j++) begin
        mem[AW'(int'(beat_cnt) * PPB + j)] <= s_axis_tdata[j*DW +: DW];
      end
    end
    if (issue) begin
      for (int i = 0; i < K; i++) begin
        ram_q[i] <= mem[rd_addr[i]];
      end
    end
    if (push) begin
      fifo_mem[fifo_wp] <= rd_slice;
    end
  end

  // Read-stage qualifiers travel alongside the RAM data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid     <= 1'b0;
      rd_mask      <= '0;
      rd_row_last  <= 1'b0;
      rd_pass_last <= 1'b0;
      rd_fin       <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_mask      <= lane_ok;
        rd_row_last  <= gen_row_last;
        rd_pass_last <= gen_pass_last;
        rd_fin       <= gen_fin;
      end
    end
  end

  // Skid FIFO pointers and the output register. The output register only
  // changes when empty or on a handshake, so stalled slices hold stable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
      o_valid     <= 1'b0;
      o_col       <= '0;
      o_row_last  <= 1'b0;
      o_pass_last <= 1'b0;
      o_fin       <= 1'b0;
    end else begin
      if (push) begin
        fifo_wp <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      if (pop) begin
        o_valid     <= 1'b1;
        o_col       <= fifo_mem[fifo_rp].col;
        o_row_last  <= fifo_mem[fifo_rp].row_last;
        o_pass_last <= fifo_mem[fifo_rp].pass_last;
        o_fin       <= fifo_mem[fifo_rp].fin;
      end else if (out_hs) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_in_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_in_line_buffer
//
// Two instances: the default 48x48/K=5 configuration and a small 4x3/K=3 one.
// Expected slices come from exp_col(), which builds each lane directly from
// the frame pattern pixel(addr) = (addr + base) mod 256.
// -----------------------------------------------------------------------------
module tb_in_line_buffer;

  localparam int B_K    = 5;
  localparam int B_W    = 48;
  localparam int B_H    = 48;
  localparam int B_NB   = 576;
  localparam int B_COLS = 52;
  localparam int B_SPP  = B_H * B_COLS;

  localparam int S_K    = 3;
  localparam int S_W    = 4;
  localparam int S_H    = 3;
  localparam int S_NB   = 3;
  localparam int S_COLS = 6;
  localparam int S_SPP  = S_H * S_COLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic [31:0] b_tdata;
  logic        b_tvalid, b_tlast, b_tready, b_start;
  logic [7:0]  b_repeat;
  logic [39:0] b_col;
  logic        b_valid, b_ready, b_row_last, b_pass_last, b_done, b_err;

  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready, s_start;
  logic [7:0]  s_repeat;
  logic [23:0] s_col;
  logic        s_valid, s_ready, s_row_last, s_pass_last, s_done, s_err;

  in_line_buffer u_big (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
    .s_axis_tready(b_tready), .i_start(b_start), .i_repeat(b_repeat),
    .o_col(b_col), .o_valid(b_valid), .i_ready(b_ready),
    .o_row_last(b_row_last), .o_pass_last(b_pass_last),
    .o_done(b_done), .o_err(b_err)
  );

  in_line_buffer #(.DW(8), .BEAT_W(32), .IMG_W(S_W), .IMG_H(S_H), .K(S_K)) u_small (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready), .i_start(s_start), .i_repeat(s_repeat),
    .o_col(s_col), .o_valid(s_valid), .i_ready(s_ready),
    .o_row_last(s_row_last), .o_pass_last(s_pass_last),
    .o_done(s_done), .o_err(s_err)
  );

  int n_vec = 0;
  int n_miscompare = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_col(input int k, input int w, input int h,
                                          input int r, input int c, input int base);
    int pad;
    logic [63:0] v;
    pad = (k - 1) / 2;
    v   = '0;
    for (int i = 0; i < k; i++) begin
      int row;
      int col;
      row = r - pad + i;
      col = c - pad;
      if (row >= 0 && row < h && col >= 0 && col < w)
        v = v | (64'((row * w + col + base) & 255) << (i * 8));
    end
    return v;
  endfunction

  function automatic logic [31:0] beat_data(input int b, input int base);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'((4 * b + j + base) & 255);
    return d;
  endfunction

  // ---------------------------------------------------------------- big DUT
  task automatic start_big(input int rep);
    @(negedge clk);
    b_start  = 1'b1;
    b_repeat = 8'(rep);
    @(negedge clk);
    b_start = 1'b0;
    check("start_tready", 64'(b_tready), 64'd1);
    check("start_err_clear", 64'(b_err), 64'd0);
  endtask

  task automatic load_big(input int base, input int early_beat, input bit poke_start);
    for (int b = 0; b < B_NB; b++) begin
      int g;
      @(negedge clk);
      b_start = 1'b0;
      if (b % 37 == 5) begin
        b_tvalid = 1'b0;
        @(negedge clk);
      end
      if (poke_start && b == 200) begin
        b_start  = 1'b1;
        b_repeat = 8'd5;
      end
      b_tvalid = 1'b1;
      b_tdata  = beat_data(b, base);
      b_tlast  = (early_beat >= 0) ? (b == early_beat) : (b == B_NB - 1);
      g = 0;
      while (!b_tready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        check("load_tready_timeout", 64'(b_tready), 64'd1);
        break;
      end
    end
    @(negedge clk);
    b_tvalid = 1'b0;
    b_tlast  = 1'b0;
    b_start  = 1'b0;
  endtask

  task automatic run_big(input int rep, input int base, input bit rand_rdy,
                         input int abort_idx, input int poke_idx);
    int total, idx, cyc, first, gaps, budget, bad_done;
    bit stall, want_done, fin;
    logic [63:0] held, e;
    total = (rep + 1) * B_SPP;
    idx = 0; cyc = 0; first = -1; gaps = 0; bad_done = 0;
    budget = total * 3 + 200;
    stall = 0; want_done = 0; fin = 0; held = '0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      b_start = 1'b0;
      if (want_done) begin
        check("done_pulse", 64'(b_done), 64'd1);
        fin = 1;
      end else begin
        if (b_done) bad_done++;
        if (stall) check("hold", 64'({b_col, b_row_last, b_pass_last, b_valid}), held);
        if (b_valid && first < 0) first = cyc;
        if (!b_valid && first >= 0) gaps++;
        b_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (abort_idx >= 0 && idx == abort_idx && b_valid) begin
          rstn = 1'b0;
          @(negedge clk);
          check("abort_valid", 64'(b_valid), 64'd0);
          check("abort_tready", 64'(b_tready), 64'd0);
          check("abort_col", 64'(b_col), 64'd0);
          check("abort_flags", 64'({b_row_last, b_pass_last, b_done, b_err}), 64'd0);
          rstn = 1'b1;
          return;
        end
        if (b_valid && b_ready) begin
          int r, c;
          r = (idx % B_SPP) / B_COLS;
          c = idx % B_COLS;
          e = exp_col(B_K, B_W, B_H, r, c, base);
          check("slice", 64'({b_col, b_row_last, b_pass_last}),
                (e << 2) | 64'({c == B_COLS - 1, (c == B_COLS - 1) && (r == B_H - 1)}));
          if (base == 0 && idx == 2) check("r0c2", 64'(b_col), 64'h60_3000_0000);
          if (idx == total - 1) want_done = 1;
          idx++;
          stall = 0;
          if (idx == poke_idx) begin
            b_start  = 1'b1;
            b_repeat = 8'd9;
          end
        end else if (b_valid) begin
          stall = 1;
          held  = 64'({b_col, b_row_last, b_pass_last, b_valid});
        end else begin
          stall = 0;
        end
      end
    end
    if (!fin) check("done_timeout", 64'(idx), 64'(total));
    check("slice_count", 64'(idx), 64'(total));
    check("first_latency_ok", 64'(first >= 1 && first <= 3), 64'd1);
    check("spurious_done", 64'(bad_done), 64'd0);
    if (!rand_rdy) check("gaps", 64'(gaps), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(b_done), 64'd0);
  endtask

  // -------------------------------------------------------------- small DUT
  task automatic run_small(input int rep);
    int total, idx, cyc;
    bit want_done, fin;
    logic [63:0] e;
    @(negedge clk);
    s_start  = 1'b1;
    s_repeat = 8'(rep);
    @(negedge clk);
    s_start = 1'b0;
    for (int b = 0; b < S_NB; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat_data(b, 1);
      s_tlast  = (b == S_NB - 1);
      check("small_tready", 64'(s_tready), 64'd1);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_ready  = 1'b1;
    total = (rep + 1) * S_SPP;
    idx = 0; cyc = 0; want_done = 0; fin = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (want_done) begin
        check("small_done", 64'(s_done), 64'd1);
        fin = 1;
      end else if (s_valid) begin
        int r, c;
        r = (idx % S_SPP) / S_COLS;
        c = idx % S_COLS;
        e = exp_col(S_K, S_W, S_H, r, c, 1);
        check("small_slice", 64'({s_col, s_row_last, s_pass_last}),
              (e << 2) | 64'({c == S_COLS - 1, (c == S_COLS - 1) && (r == S_H - 1)}));
        if (idx == 7) check("small_r1c1", 64'(s_col), 64'h09_05_01);
        if (idx == 17 || idx == 35 || idx == 53) check("small_pass_last", 64'(s_pass_last), 64'd1);
        if (idx == total - 1) want_done = 1;
        idx++;
      end
    end
    check("small_count", 64'(idx), 64'(total));
    check("small_err", 64'(s_err), 64'd0);
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    rstn = 1'b0;
    b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_start = 1'b0; b_repeat = '0; b_ready = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_start = 1'b0; s_repeat = '0; s_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(b_tready), 64'd0);
    check("rst_valid", 64'(b_valid), 64'd0);
    check("rst_col", 64'(b_col), 64'd0);
    check("rst_row_last", 64'(b_row_last), 64'd0);
    check("rst_pass_last", 64'(b_pass_last), 64'd0);
    check("rst_done", 64'(b_done), 64'd0);
    check("rst_err", 64'(b_err), 64'd0);
    check("rst_small", 64'({s_tready, s_valid, s_col}), 64'd0);
    rstn = 1'b1;

    // Small geometry: three passes over a 4x3 frame holding 1..12.
    run_small(2);

    // Ramp frame, single pass, i_ready high; i_start poked in LOAD and SEND.
    start_big(0);
    load_big(0, -1, 1'b1);
    run_big(0, 0, 1'b0, -1, 1000);
    check("ramp_err", 64'(b_err), 64'd0);

    // Early tlast on beat 100 (and none on the last beat), random i_ready.
    start_big(1);
    load_big(7, 100, 1'b0);
    check("err_set", 64'(b_err), 64'd1);
    run_big(1, 7, 1'b1, -1, -1);
    check("err_sticky", 64'(b_err), 64'd1);

    // Reset at pass 1, row 20, then a fresh load replays a new frame.
    start_big(1);
    load_big(3, -1, 1'b0);
    run_big(1, 3, 1'b0, B_SPP + 20 * B_COLS, -1);
    start_big(0);
    load_big(11, -1, 1'b0);
    run_big(0, 11, 1'b0, -1, -1);
    check("final_err", 64'(b_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
